// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_REQ
    } state_e;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_GO       = 8'h02;

    localparam logic [1:0] ERR_BAD_CMD  = 2'd0;
    localparam logic [1:0] ERR_CSUM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Width of the inter-byte timeout counter.
    localparam int TMO_W = 24;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Assembles framed UART bytes into 32-bit write requests or a boot-release pulse,
// with XOR checksum, inter-byte timeout and overrun detection.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Req_Valid,
    input  logic        i_Req_Ready,
    output logic [31:0] o_Req_Addr,
    output logic [31:0] o_Req_Wdata,
    output logic        o_Boot_Go,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code,
    output logic        o_Busy
);

    // Expiry is seen when the counter holds TIMEOUT_CLKS-1 going into an edge
    // with no byte, so the error lands TIMEOUT_CLKS edges after the last byte.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    state_e            state_q;
    logic [1:0]        idx_q;
    logic              is_go_q;
    logic [7:0]        csum_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              req_valid_q;
    logic [31:0]       req_addr_q;
    logic [31:0]       req_wdata_q;
    logic              boot_go_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic              busy_q;

    logic [TMO_W-1:0]  tmo_cnt_d;
    logic [7:0]        csum_d;
    logic [1:0]        idx_d;
    logic [4:0]        lane;
    logic              timer_active;
    logic              tmo_hit;

    // Next-state helpers: timeout counting, running checksum, byte lane select.
    always_comb begin
        timer_active = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);
        tmo_cnt_d    = (i_Rx_DV || !timer_active) ? '0 : tmo_cnt_q + 1'b1;
        tmo_hit      = timer_active && (tmo_cnt_q == TMO_LAST);
        csum_d       = csum_q ^ i_Rx_Byte;
        idx_d        = idx_q + 2'd1;
        lane         = {idx_q, 3'b000};
    end

    // Frame decoder FSM; every output is a register updated here.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            is_go_q     <= 1'b0;
            csum_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tmo_cnt_q   <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            boot_go_q   <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            boot_go_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt_q <= tmo_cnt_d;

            case (state_q)
                ST_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_q <= ST_CMD;
                        csum_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_CMD: begin
                    if (i_Rx_DV) begin
                        csum_q <= i_Rx_Byte;
                        if (i_Rx_Byte == CMD_WRITE) begin
                            is_go_q <= 1'b0;
                            state_q <= ST_ADDR;
                        end else if (i_Rx_Byte == CMD_GO) begin
                            is_go_q <= 1'b1;
                            state_q <= ST_CSUM;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_BAD_CMD;
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        tmo_cnt_q  <= '0;
                    end
                end

                ST_ADDR, ST_DATA: begin
                    if (i_Rx_DV) begin
                        if (state_q == ST_ADDR) begin
                            addr_q[lane +: 8] <= i_Rx_Byte;
                        end else begin
                            data_q[lane +: 8] <= i_Rx_Byte;
                        end
                        csum_q <= csum_d;
                        idx_q  <= idx_d;
                        if (idx_q == 2'd3) begin
                            state_q <= (state_q == ST_ADDR) ? ST_DATA : ST_CSUM;
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        tmo_cnt_q  <= '0;
                    end
                end

                ST_CSUM: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte != csum_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CSUM;
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                        end else if (is_go_q) begin
                            boot_go_q <= 1'b1;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            req_valid_q <= 1'b1;
                            req_addr_q  <= addr_q;
                            req_wdata_q <= data_q;
                            state_q     <= ST_REQ;
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        tmo_cnt_q  <= '0;
                    end
                end

                ST_REQ: begin
                    // A byte here cannot be buffered: flag it, keep the request.
                    if (i_Rx_DV) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_OVERRUN;
                    end
                    if (i_Req_Ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Req_Valid = req_valid_q;
    assign o_Req_Addr  = req_addr_q;
    assign o_Req_Wdata = req_wdata_q;
    assign o_Boot_Go   = boot_go_q;
    assign o_Err       = err_q;
    assign o_Err_Code  = err_code_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus randomized
// frames scored against a frame-level reference model.
module tb_uart_cmd_decoder;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          kind;   // 0 request handshake, 1 boot go, 2 error
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  code;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        dv;
    logic [7:0]  rx;
    logic        ready;
    logic        o_Req_Valid;
    logic [31:0] o_Req_Addr;
    logic [31:0] o_Req_Wdata;
    logic        o_Boot_Go;
    logic        o_Err;
    logic [1:0]  o_Err_Code;
    logic        o_Busy;

    int n_total;
    int n_pass;
    int n_fail;
    ev_t evq[$];

    uart_cmd_decoder #(
        .TIMEOUT_CLKS (100),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_DV     (dv),
        .i_Rx_Byte   (rx),
        .o_Req_Valid (o_Req_Valid),
        .i_Req_Ready (ready),
        .o_Req_Addr  (o_Req_Addr),
        .o_Req_Wdata (o_Req_Wdata),
        .o_Boot_Go   (o_Boot_Go),
        .o_Err       (o_Err),
        .o_Err_Code  (o_Err_Code),
        .o_Busy      (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event recorder: inputs change just after posedge, so at negedge
    // valid&&ready means the handshake happens on the coming edge.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (o_Req_Valid && ready) begin
                e.kind = 0; e.a = o_Req_Addr; e.d = o_Req_Wdata; e.code = 2'd0;
                evq.push_back(e);
            end
            if (o_Boot_Go) begin
                e.kind = 1; e.a = '0; e.d = '0; e.code = 2'd0;
                evq.push_back(e);
            end
            if (o_Err) begin
                e.kind = 2; e.a = '0; e.d = '0; e.code = o_Err_Code;
                evq.push_back(e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx = b;
        tick();
        dv = 1'b0;
        rx = 8'h00;
    endtask

    task automatic send_frame(input bq_t fr, input int maxgap);
        foreach (fr[i]) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) tick();
            send(fr[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, o_Req_Valid}, 32'd0);
        check({tag, "_addr"},  o_Req_Addr,           32'd0);
        check({tag, "_wdata"}, o_Req_Wdata,          32'd0);
        check({tag, "_go"},    {31'b0, o_Boot_Go},   32'd0);
        check({tag, "_err"},   {31'b0, o_Err},       32'd0);
        check({tag, "_code"},  {30'b0, o_Err_Code},  32'd0);
        check({tag, "_busy"},  {31'b0, o_Busy},      32'd0);
    endtask

    // Builds a well-formed WRITE frame: checksum is the XOR of CMD..DATA bytes.
    function automatic bq_t build_write(input logic [31:0] a, input logic [31:0] d);
        bq_t fr;
        logic [7:0] x;
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(8'h01);
        for (int i = 0; i < 4; i++) fr.push_back(8'((a >> (8 * i)) & 32'hFF));
        for (int i = 0; i < 4; i++) fr.push_back(8'((d >> (8 * i)) & 32'hFF));
        x = 8'h00;
        for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
        fr.push_back(x);
        return fr;
    endfunction

    // Frame-level reference: skip to SYNC, read command, rebuild the fields
    // arithmetically and judge the trailing checksum.
    function automatic void model(input bq_t fr, output int kind, output logic [31:0] a,
                                  output logic [31:0] d, output logic [1:0] code);
        int i;
        logic [7:0] x;
        kind = -1; a = '0; d = '0; code = 2'd0;
        i = 0;
        while (i < fr.size() && fr[i] != 8'hA5) i++;
        i++;
        if (fr[i] == 8'h01) begin
            x = 8'h00;
            for (int j = 0; j < 9; j++) x = x ^ fr[i + j];
            for (int j = 0; j < 4; j++) begin
                a = a + (32'(fr[i + 1 + j]) << (8 * j));
                d = d + (32'(fr[i + 5 + j]) << (8 * j));
            end
            if (fr[i + 9] == x) kind = 0;
            else begin kind = 2; code = 2'd1; end
        end else if (fr[i] == 8'h02) begin
            if (fr[i + 1] == 8'h02) kind = 1;
            else begin kind = 2; code = 2'd1; end
        end else begin
            kind = 2; code = 2'd0;
        end
    endfunction

    initial begin
        bq_t fr;
        int ek, rdly, w;
        logic [31:0] ea, ed, ra, rd;
        logic [1:0]  ec;
        logic [7:0]  b, cs;

        n_total = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; dv = 1'b0; rx = 8'h00; ready = 1'b0;

        // Reset state
        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // WRITE frame from the example, ready held low for 5 cycles
        evq.delete();
        fr = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(fr, 0);
        check("wr_valid_before_csum", {31'b0, o_Req_Valid}, 32'd0);
        check("wr_busy_in_frame", {31'b0, o_Busy}, 32'd1);
        send(8'hB3);
        check("wr_valid_latency", {31'b0, o_Req_Valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("wr_hold_valid", {31'b0, o_Req_Valid}, 32'd1);
            check("wr_hold_addr", o_Req_Addr, 32'h8000_0010);
            check("wr_hold_data", o_Req_Wdata, 32'hDEAD_BEEF);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("wr_valid_fall", {31'b0, o_Req_Valid}, 32'd0);
        check("wr_busy_after", {31'b0, o_Busy}, 32'd0);
        tick();
        check("wr_nhandshake", evq.size(), 32'd1);

        // GO frames: good and bad checksum
        evq.delete();
        send(8'hA5); send(8'h02); send(8'h02);
        check("go_pulse", {31'b0, o_Boot_Go}, 32'd1);
        check("go_no_valid", {31'b0, o_Req_Valid}, 32'd0);
        tick();
        check("go_pulse_width", {31'b0, o_Boot_Go}, 32'd0);
        send(8'hA5); send(8'h02); send(8'h03);
        check("gobad_err", {31'b0, o_Err}, 32'd1);
        check("gobad_code", {30'b0, o_Err_Code}, 32'd1);
        check("gobad_no_go", {31'b0, o_Boot_Go}, 32'd0);
        tick();
        check("go_nevents", evq.size(), 32'd2);

        // Garbage bytes in idle, then an unknown command
        evq.delete();
        send(8'h00); send(8'hFF); send(8'h13);
        check("garbage_busy", {31'b0, o_Busy}, 32'd0);
        check("garbage_quiet", evq.size(), 32'd0);
        send(8'hA5); send(8'h07);
        check("badcmd_err", {31'b0, o_Err}, 32'd1);
        check("badcmd_code", {30'b0, o_Err_Code}, 32'd0);
        tick();
        check("badcmd_busy", {31'b0, o_Busy}, 32'd0);
        check("badcmd_err_width", {31'b0, o_Err}, 32'd0);

        // Timeout fires exactly TIMEOUT_CLKS cycles after the last byte
        send(8'hA5); send(8'h01); send(8'h12);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 99) check("tmo_early", {31'b0, o_Err}, 32'd0);
        end
        check("tmo_err", {31'b0, o_Err}, 32'd1);
        check("tmo_code", {30'b0, o_Err_Code}, 32'd2);
        tick();
        check("tmo_busy", {31'b0, o_Busy}, 32'd0);

        // Byte arriving on the expiry edge wins; following frame decodes
        evq.delete();
        fr = build_write(32'h1234_5678, 32'hCAFE_F00D);
        send(fr[0]);
        repeat (99) tick();
        for (int i = 1; i < fr.size(); i++) send(fr[i]);
        check("tmo_edge_valid", {31'b0, o_Req_Valid}, 32'd1);
        check("tmo_edge_addr", o_Req_Addr, 32'h1234_5678);
        check("tmo_edge_data", o_Req_Wdata, 32'hCAFE_F00D);
        check("tmo_edge_noerr", evq.size(), 32'd0);
        ready = 1'b1; tick(); ready = 1'b0;

        // Overrun during REQ
        evq.delete();
        send_frame(build_write(32'h0000_4000, 32'h0BAD_CAFE), 0);
        tick();
        send(8'h55);
        check("ovr_err", {31'b0, o_Err}, 32'd1);
        check("ovr_code", {30'b0, o_Err_Code}, 32'd3);
        check("ovr_valid", {31'b0, o_Req_Valid}, 32'd1);
        check("ovr_addr", o_Req_Addr, 32'h0000_4000);
        check("ovr_data", o_Req_Wdata, 32'h0BAD_CAFE);
        tick();
        check("ovr_busy", {31'b0, o_Busy}, 32'd1);
        ready = 1'b1; tick(); ready = 1'b0;
        check("ovr_done", {31'b0, o_Req_Valid}, 32'd0);

        // Reset mid-ADDR and with a request pending
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs("rst_addr");
        send_frame(build_write(32'hFFFF_FFFC, 32'h0000_0001), 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs("rst_req");
        evq.delete();
        ready = 1'b1;
        send_frame(build_write(32'h2000_0000, 32'h5A5A_A5A5), 0);
        check("fresh_addr", o_Req_Addr, 32'h2000_0000);
        check("fresh_data", o_Req_Wdata, 32'h5A5A_A5A5);
        tick();
        ready = 1'b0;
        check("fresh_valid_fall", {31'b0, o_Req_Valid}, 32'd0);
        check("fresh_nhandshake", evq.size(), 32'd1);

        // Randomized frames scored against the reference model
        for (int f = 0; f < 40; f++) begin
            fr = {};
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                fr.push_back(b);
            end
            w = $urandom_range(9, 0);
            if (w == 0) begin
                fr.push_back(8'hA5);
                fr.push_back(8'($urandom_range(255, 3)));
            end else if (w <= 3) begin
                cs = 8'h02;
                if ($urandom_range(3, 0) == 0) cs = cs ^ (8'h01 << $urandom_range(7, 0));
                fr.push_back(8'hA5); fr.push_back(8'h02); fr.push_back(cs);
            end else begin
                ra = $urandom; rd = $urandom;
                fr = {fr, build_write(ra, rd)};
                if ($urandom_range(3, 0) == 0)
                    fr[fr.size() - 1] = fr[fr.size() - 1] ^ (8'h01 << $urandom_range(7, 0));
            end
            model(fr, ek, ea, ed, ec);
            evq.delete();
            rdly = $urandom_range(3, 0);
            ready = (rdly == 0);
            send_frame(fr, 3);
            if (ek == 0) begin
                repeat (rdly) tick();
                if (rdly > 0) check("rnd_hold_addr", o_Req_Addr, ea);
                ready = 1'b1;
                w = 0;
                while (o_Req_Valid && w < 20) begin tick(); w++; end
                check("rnd_valid_drop", {31'b0, o_Req_Valid}, 32'd0);
                ready = 1'b0;
            end
            tick(); tick();
            check("rnd_nevents", evq.size(), 32'd1);
            if (evq.size() >= 1) begin
                check("rnd_kind", evq[0].kind, ek);
                if (ek == 0) begin
                    check("rnd_addr", evq[0].a, ea);
                    check("rnd_data", evq[0].d, ed);
                end
                if (ek == 2) check("rnd_code", {30'b0, evq[0].code}, {30'b0, ec});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
